// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: masks channel requests, runs the HRQ/HLDA handshake and holds one DACK until end of service.
// Optional `ROTATING_PRIORITY_EN` rotates priority so the channel just served becomes lowest priority.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DREQ0,
    input  logic              DREQ1,
    input  logic              DREQ2,
    input  logic              DREQ3,
    input  logic              HLDA,
    input  logic              maskWrite,
    input  logic [NUM_CH-1:0] maskData,
    input  logic              xferDone,
    input  logic              eopIn,
    output logic              HRQ,
    output logic              DACK0,
    output logic              DACK1,
    output logic              DACK2,
    output logic              DACK3,
    output logic [1:0]        activeCh,
    output logic              grantValid,
    output logic [NUM_CH-1:0] maskReg
);

    typedef enum logic [1:0] {IDLE, HOLD_REQ, GRANT, RELEASE} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        active_ch_reg;
    logic [NUM_CH-1:0] mask_reg;
    logic [NUM_CH-1:0] dreq, req, req_rot, dack;
    logic [1:0]        top_pri, win_off, winner;
    logic              svc_done, eop_set, latch_win;

    assign dreq = {DREQ3, DREQ2, DREQ1, DREQ0};
    assign req  = dreq & ~mask_reg;

    // A normal end of service requires HLDA still high; an HLDA drop takes the error path instead.
    assign svc_done  = (state_reg == GRANT) && HLDA && xferDone;
    assign eop_set   = svc_done && eopIn;
    assign latch_win = (state_reg == HOLD_REQ) && HLDA && (|req);

    // Rotate the request vector so bit 0 is the current top-priority channel.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign req_rot[gi] = req[2'(gi) + top_pri];
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) win_off = 2'(i);
        end
        winner = win_off + top_pri;
    end

`ifdef ROTATING_PRIORITY_EN
    logic [1:0] top_pri_reg;

    always_ff @(posedge CLK) begin
        if (!RESET)
            top_pri_reg <= 2'd0;
        else if (svc_done)
            top_pri_reg <= active_ch_reg + 2'd1;
    end

    assign top_pri = top_pri_reg;
`else
    assign top_pri = 2'd0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg     <= IDLE;
            active_ch_reg <= 2'd0;
            mask_reg      <= '1;
        end else begin
            state_reg <= state_next;
            if (latch_win)
                active_ch_reg <= winner;
            // An explicit mask write overrides the EOP auto-mask in the same cycle.
            if (maskWrite)
                mask_reg <= maskData;
            else if (eop_set)
                mask_reg[active_ch_reg] <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (|req) state_next = HOLD_REQ;
            HOLD_REQ: if (HLDA) state_next = (|req) ? GRANT : RELEASE;
            GRANT:    if (!HLDA || xferDone) state_next = RELEASE;
            RELEASE:  if (!HLDA) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        dack       = '0;
        grantValid = (state_reg == GRANT);
        HRQ        = (state_reg == HOLD_REQ) || (state_reg == GRANT);
        if (state_reg == GRANT)
            dack[active_ch_reg] = 1'b1;
    end

    assign DACK0    = dack[0];
    assign DACK1    = dack[1];
    assign DACK2    = dack[2];
    assign DACK3    = dack[3];
    assign activeCh = active_ch_reg;
    assign maskReg  = mask_reg;

endmodule
